// File: rtl/mdu_ctrl_pkg.sv
// Shared MDOp / HILOSel encodings for the E-stage multiply/divide unit.
package mdu_ctrl_pkg;

    localparam logic [2:0] MD_NONE  = 3'b000;
    localparam logic [2:0] MD_MULT  = 3'b001;
    localparam logic [2:0] MD_MULTU = 3'b010;
    localparam logic [2:0] MD_DIV   = 3'b011;
    localparam logic [2:0] MD_DIVU  = 3'b100;
    localparam logic [2:0] MD_MTHI  = 3'b101;
    localparam logic [2:0] MD_MTLO  = 3'b110;
    localparam logic [2:0] MD_MADD  = 3'b111;

    localparam logic SEL_HI = 1'b0;
    localparam logic SEL_LO = 1'b1;

    // Ops that occupy the unit for a busy period.
    function automatic logic is_multi_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) ||
               (op == MD_DIVU) || (op == MD_MADD);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit result generator for mult/multu/div/divu/madd.
// A divide by zero returns the current HI/LO so that the later commit
// leaves the architectural registers untouched.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] divisor;
    logic        [31:0] quo_s;
    logic        [31:0] rem_s;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;

    // Compute every candidate result, then select by opcode.
    always_comb begin
        prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u  = {32'd0, a} * {32'd0, b};
        // Dummy divisor keeps the dividers well defined when b is zero.
        divisor = (b == 32'd0) ? 32'd1 : b;
        quo_s   = $signed(a) / $signed(divisor);
        rem_s   = $signed(a) % $signed(divisor);
        quo_u   = a / divisor;
        rem_u   = a % divisor;

        {res_hi, res_lo} = {hi, lo};
        case (md_op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV:   if (b != 32'd0) {res_hi, res_lo} = {rem_s, quo_s};
            MD_DIVU:  if (b != 32'd0) {res_hi, res_lo} = {rem_u, quo_u};
            MD_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
            default:  {res_hi, res_lo} = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: owns HI/LO, sequences multi-cycle
// operations with a busy down-counter, and raises the D-stage stall.
// Results sit in pending registers until the counter reaches terminal
// count, so mfhi/mflo only ever see committed values.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MDOp,
    input  logic        HILOSel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    input  logic        isMD_D,
    output logic        Start,
    output logic        Busy,
    output logic        MDStall,
    output logic [31:0] HILORd
);

    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [31:0]      res_hi, res_lo;
    logic             start_op;
    logic             commit;

    mdu_arith u_arith (
        .md_op  (MDOp),
        .a      (A),
        .b      (B),
        .hi     (hi_q),
        .lo     (lo_q),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // Accept, stall and read-port outputs; all quiet while in reset.
    always_comb begin
        start_op = is_multi_op(MDOp) & ~busy_q & ~Req & ~reset;
        Start    = start_op;
        Busy     = busy_q;
        MDStall  = isMD_D & (start_op | busy_q) & ~reset;
        HILORd   = (HILOSel == SEL_LO) ? lo_q : hi_q;
    end

    // Last busy cycle is the one where the counter sits at one.
    assign commit = busy_q && (cnt_q == CNT_W'(1));

    // Next-state: count down while busy, launch new ops, apply mthi/mtlo.
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        if (busy_q) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (commit) begin
                hi_d   = pend_hi_q;
                lo_d   = pend_lo_q;
                busy_d = 1'b0;
            end
        end else if (start_op) begin
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            busy_d    = 1'b1;
            cnt_d     = is_div_op(MDOp) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        end else if (!Req) begin
            if (MDOp == MD_MTHI) hi_d = A;
            if (MDOp == MD_MTLO) lo_d = A;
        end
    end

    // State registers; reset discards any in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
        end
    end

endmodule
